shift_left_seq: RTL and testbench

SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

---
 rtl/shift_left_seq.sv | 140 ++++++++++++++
 tb/tb_shift_left_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_left_seq.sv
// shift_left_seq: sequential 16-bit barrel-style left shifter.
//
// A request (start in IDLE) captures the operand, a 4-bit shift amount and the
// shift mode. Four SHIFT cycles each conditionally apply a shift of 1, 2, 4
// and 8 bits, selected by the bits of the captured amount. The result is
// presented on out together with a one-cycle done pulse. Latency is the same
// for every amount, including zero.
//
// Optional feature: define SHL_ROTATE_EN to build rotate mode (rot=1 feeds the
// bits leaving bit 15 back into the LSBs). Without it, rot is ignored, every
// operation is a logical (zero-fill) shift and no mode register exists.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request strobe, only looked at in IDLE
//   in     in  16   operand
//   cnt    in   4   shift amount 0..15
//   rot    in   1   0 = logical shift, 1 = rotate (SHL_ROTATE_EN only)
//   busy   out  1   high whenever the FSM is not in IDLE
//   done   out  1   one-cycle pulse, out is valid while it is high
//   out    out 16   result register, holds until the next result or reset
//
// state | meaning
// IDLE  | waiting for start, out holds the last result
// SHIFT | stage 0..3 applies a shift of 2**stage if cnt_reg[stage] is set
// DONE  | out carries the new result, done pulses, back to IDLE next

module shift_left_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    input  logic        rot,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] work_q;
    logic [3:0]  cnt_q;
    logic [1:0]  stage_q;
    logic [15:0] lsl_val;
    logic [15:0] stage_val;

`ifdef SHL_ROTATE_EN
    logic        mode_q;
    logic [15:0] rol_val;
`else
    logic        unused_rot;
    assign unused_rot = rot;
`endif

    // Shift candidate for the current stage (amount 1, 2, 4 or 8).
    always_comb begin
        lsl_val = work_q;
        unique case (stage_q)
            2'd0: lsl_val = {work_q[14:0], 1'b0};
            2'd1: lsl_val = {work_q[13:0], 2'b0};
            2'd2: lsl_val = {work_q[11:0], 4'b0};
            2'd3: lsl_val = {work_q[7:0],  8'b0};
            default: lsl_val = work_q;
        endcase
    end

`ifdef SHL_ROTATE_EN
    always_comb begin
        rol_val = work_q;
        unique case (stage_q)
            2'd0: rol_val = {work_q[14:0], work_q[15]};
            2'd1: rol_val = {work_q[13:0], work_q[15:14]};
            2'd2: rol_val = {work_q[11:0], work_q[15:12]};
            2'd3: rol_val = {work_q[7:0],  work_q[15:8]};
            default: rol_val = work_q;
        endcase
    end

    assign stage_val = cnt_q[stage_q] ? (mode_q ? rol_val : lsl_val) : work_q;
`else
    assign stage_val = cnt_q[stage_q] ? lsl_val : work_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (stage_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= 16'h0000;
            cnt_q   <= 4'h0;
            stage_q <= 2'd0;
            out     <= 16'h0000;
`ifdef SHL_ROTATE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= in;
                        cnt_q   <= cnt;
                        stage_q <= 2'd0;
`ifdef SHL_ROTATE_EN
                        mode_q  <= rot;
`endif
                    end
                end
                SHIFT: begin
                    work_q  <= stage_val;
                    stage_q <= stage_q + 2'd1;
                    // Result register is written on entry to DONE so it is
                    // already valid during the done pulse.
                    if (stage_q == 2'd3) out <= stage_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_left_seq.sv
// Testbench for shift_left_seq: directed cases plus randomized operations
// with bus noise and stray start strobes while busy, checked against an
// arithmetic reference model. Edge T is the edge that samples start; outputs
// are observed 1 time unit after each edge, so the sample after edge T+k
// reflects the clock period that ends at edge T+k+1.

module tb_shift_left_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic        rot;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    shift_left_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in),
        .cnt   (cnt),
        .rot   (rot),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operand.
    function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [3:0] c, input logic r);
        logic [31:0] wide;
        logic [31:0] dbl;
        wide = {16'h0000, a} << c;
        dbl  = {a, a} << c;
`ifdef SHL_ROTATE_EN
        if (r) return dbl[31:16];
`else
        if (r) return wide[15:0];
`endif
        return wide[15:0];
    endfunction

    // One complete operation. With noise set, in/cnt/rot are scrambled and
    // start is randomly asserted during the busy window.
    task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic r,
                          input logic [15:0] exp, input bit noise, input string tag);
        int ndone;
        ndone = 0;
        @(negedge clk);
        in = a; cnt = c; rot = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) ndone++;
            if (k == 4) begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_out"}, 32'(out), 32'(exp));
            end else begin
                check({tag, "_nodone"}, 32'(done), 32'd0);
            end
            if (noise) begin
                in    = 16'($urandom);
                cnt   = 4'($urandom);
                rot   = 1'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(out), 32'(exp));
        check({tag, "_npulse"}, 32'(ndone), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [3:0]  c;
        logic        r;
        int          saw_done;
        rst = 1'b1; start = 1'b0; in = 16'h0; cnt = 4'h0; rot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h8001, 4'd1, 1'b0, 16'h0002, 1'b0, "lsl_8001_1");
        run_op(16'h00FF, 4'd4, 1'b0, 16'h0FF0, 1'b0, "lsl_00ff_4");
        run_op(16'h0003, 4'd15, 1'b0, 16'h8000, 1'b0, "lsl_0003_15");
        run_op(16'h1234, 4'd0, 1'b0, 16'h1234, 1'b0, "cnt0");
`ifdef SHL_ROTATE_EN
        run_op(16'h8001, 4'd1, 1'b1, 16'h0003, 1'b0, "rot_8001_1");
`else
        run_op(16'h8001, 4'd1, 1'b1, 16'h0002, 1'b0, "rot_8001_1");
`endif

        // Second start at T+2 with different operands must be ignored.
        @(negedge clk);
        in = 16'h00FF; cnt = 4'd4; rot = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 0;
        @(posedge clk); #1;
        in = 16'hFFFF; cnt = 4'd9; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) saw_done++;
        end
        check("ign_done", 32'(done), 32'd1);
        check("ign_out", 32'(out), 32'h0FF0);
        @(posedge clk); #1;
        if (done) saw_done++;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("ign_npulse", 32'(saw_done), 32'd1);
        check("ign_idle", 32'(busy), 32'd0);

        // Reset sampled at T+2 aborts the operation.
        @(negedge clk);
        in = 16'h1234; cnt = 4'd3; rot = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'(out), 32'h0);
        saw_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done++;
        end
        check("abort_quiet", 32'(saw_done), 32'd0);

        // start together with rst is discarded.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; in = 16'h0001; cnt = 4'd2;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_out", 32'(out), 32'h0);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            c = 4'($urandom);
            r = 1'($urandom);
            run_op(a, c, r, ref_result(a, c, r), 1'b1, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
